// File: rtl/pow_pkg.sv
// Shared constants for the sequential power unit: default widths, FSM encodings
// and the data-independent request latency used by anything that schedules around it.
package pow_pkg;

    localparam int POW_WIDTH = 8;
    localparam int POW_EXP_W = 3;
    localparam int POW_OUT_W = 24;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Edges from the accepting start edge to the edge that raises valid_o.
    function automatic int unsigned lat(input int unsigned e, input int unsigned width);
        return (e <= 1) ? 1 : 1 + (e - 1) * width;
    endfunction

endpackage

// File: rtl/pow_seq_serial_mul.sv
// Bit-serial shift-add multiplier: OUT_W x WIDTH product in WIDTH cycles after load,
// done/product/overflow valid combinationally in the last cycle; no backpressure.
module serial_mul #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [OUT_W-1:0] acc_i,
    input  logic [WIDTH-1:0] a_i,
    output logic             done_o,
    output logic [OUT_W-1:0] prod_o,
    output logic             ovf_o
);

    localparam int PW = OUT_W + WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic          run_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0] psum_q;
    logic [PW-1:0] psum_nxt;

    assign psum_nxt = psum_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o   = run_q && (cnt_q == CW'(WIDTH - 1));
    assign prod_o   = psum_nxt[OUT_W-1:0];
    assign ovf_o    = |psum_nxt[PW-1:OUT_W];

    // A load in the finishing cycle restarts immediately, so chained multiplies have no gap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            psum_q   <= '0;
        end else if (load_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, acc_i};
            mplier_q <= a_i;
            psum_q   <= '0;
        end else if (run_q) begin
            psum_q   <= psum_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pow_seq.sv
// Sequential power y = a^e: 1 + (e-1)*WIDTH cycles for e>=2, else 1; one-cycle valid_o pulse.
// No backpressure: start_i is ignored while busy_o, accepted again in the valid_o cycle.
module pow_seq
    import pow_pkg::*;
#(
    parameter int WIDTH = POW_WIDTH,
    parameter int EXP_W = POW_EXP_W,
    parameter int OUT_W = POW_OUT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [EXP_W-1:0] e_bi,
    input  logic             start_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [OUT_W-1:0] y_bo,
    output logic             ovf_o
);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [OUT_W-1:0] acc_q;
    logic [EXP_W-1:0] mul_left_q;
    logic             ovf_q;
    logic [OUT_W-1:0] y_q;
    logic             ovf_out_q;
    logic             valid_q;

    logic             mul_load;
    logic [OUT_W-1:0] mul_acc;
    logic [WIDTH-1:0] mul_a;
    logic             mul_done;
    logic [OUT_W-1:0] mul_prod;
    logic             mul_ovf;

    assign busy_o  = (state_q != ST_IDLE);
    assign valid_o = valid_q;
    assign y_bo    = y_q;
    assign ovf_o   = ovf_out_q;

    // First multiply is a*a straight from the inputs; later ones chain the fresh product.
    always_comb begin
        mul_load = 1'b0;
        mul_acc  = mul_prod;
        mul_a    = a_q;
        if (state_q == ST_IDLE && start_i && e_bi > EXP_W'(1)) begin
            mul_load = 1'b1;
            mul_acc  = OUT_W'(a_bi);
            mul_a    = a_bi;
        end else if (state_q == ST_MUL && mul_done && mul_left_q != EXP_W'(1)) begin
            mul_load = 1'b1;
        end
    end

    serial_mul #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (mul_load),
        .acc_i   (mul_acc),
        .a_i     (mul_a),
        .done_o  (mul_done),
        .prod_o  (mul_prod),
        .ovf_o   (mul_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            acc_q      <= '0;
            mul_left_q <= '0;
            ovf_q      <= 1'b0;
            y_q        <= '0;
            ovf_out_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        a_q        <= a_bi;
                        acc_q      <= (e_bi == '0) ? OUT_W'(1) : OUT_W'(a_bi);
                        mul_left_q <= (e_bi == '0) ? '0 : e_bi - EXP_W'(1);
                        ovf_q      <= 1'b0;
                        state_q    <= (e_bi <= EXP_W'(1)) ? ST_DONE : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        acc_q      <= mul_prod;
                        ovf_q      <= ovf_q | mul_ovf;
                        mul_left_q <= mul_left_q - EXP_W'(1);
                        if (mul_left_q == EXP_W'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    y_q       <= acc_q;
                    ovf_out_q <= ovf_q;
                    valid_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pow_seq.sv
// Directed and randomised checks of pow_seq: results, overflow, latency, busy/valid timing,
// ignored starts, back-to-back issue and asynchronous reset mid-operation.
module tb_pow_seq;
    import pow_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  a_bi;
    logic [2:0]  e_bi;
    logic        start_i;
    logic        busy_o;
    logic        valid_o;
    logic [23:0] y_bo;
    logic        ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    pow_seq dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .a_bi    (a_bi),
        .e_bi    (e_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .y_bo    (y_bo),
        .ovf_o   (ovf_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns at #1 after the edge that raised valid_o.
    task automatic wait_valid(output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run_req(input logic [7:0] a, input logic [2:0] e,
                           output int lat_seen, output logic busy0);
        a_bi    = a;
        e_bi    = e;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        busy0   = busy_o;
        wait_valid(lat_seen);
    endtask

    function automatic logic [24:0] ref_pow(input logic [7:0] a, input logic [2:0] e);
        logic [63:0] acc;
        logic [63:0] p;
        logic        ov;
        acc = (e == 3'd0) ? 64'd1 : {56'd0, a};
        ov  = 1'b0;
        for (int i = 1; i < int'(e); i++) begin
            p = acc * {56'd0, a};
            if (p[63:24] != 40'd0) ov = 1'b1;
            acc = {40'd0, p[23:0]};
        end
        return {ov, acc[23:0]};
    endfunction

    initial begin
        int          lat_seen;
        int          tail;
        int          pulses;
        logic        busy0;
        logic [7:0]  ra;
        logic [2:0]  re;
        logic [24:0] rexp;

        rst_n_i = 1'b0;
        start_i = 1'b0;
        a_bi    = '0;
        e_bi    = '0;
        #22;
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_y",     {8'd0, y_bo},     32'd0);
        check("rst_ovf",   {31'd0, ovf_o},   32'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // 3^3 with exact latency and a single-cycle pulse
        run_req(8'd3, 3'd3, lat_seen, busy0);
        check("p3_3_y",    {8'd0, y_bo},   32'd27);
        check("p3_3_ovf",  {31'd0, ovf_o}, 32'd0);
        check("p3_3_lat",  lat_seen,       32'd17);
        check("p3_3_busy", {31'd0, busy0}, 32'd1);
        check("valid_cycle_not_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("pulse_width", {31'd0, valid_o}, 32'd0);

        // Short exponents, chained back-to-back
        run_req(8'd0, 3'd0, lat_seen, busy0);
        check("p0_0_y",   {8'd0, y_bo}, 32'd1);
        check("p0_0_lat", lat_seen,     32'd1);
        run_req(8'd5, 3'd1, lat_seen, busy0);
        check("p5_1_y",   {8'd0, y_bo}, 32'd5);
        check("p5_1_lat", lat_seen,     32'd1);
        run_req(8'd0, 3'd4, lat_seen, busy0);
        check("p0_4_y",   {8'd0, y_bo}, 32'd0);
        check("p0_4_lat", lat_seen,     32'd25);

        // Overflow boundary
        run_req(8'd255, 3'd3, lat_seen, busy0);
        check("p255_3_y",   {8'd0, y_bo},   32'h00FD02FF);
        check("p255_3_ovf", {31'd0, ovf_o}, 32'd0);
        run_req(8'd255, 3'd4, lat_seen, busy0);
        check("p255_4_y",   {8'd0, y_bo},   32'h0005FC01);
        check("p255_4_ovf", {31'd0, ovf_o}, 32'd1);
        check("p255_4_lat", lat_seen,       32'd25);
        run_req(8'd3, 3'd2, lat_seen, busy0);
        check("ovf_cleared", {31'd0, ovf_o}, 32'd0);
        check("p3_2_y",      {8'd0, y_bo},   32'd9);

        // Start while busy is ignored
        @(posedge clk_i);
        #1;
        a_bi    = 8'd2;
        e_bi    = 3'd7;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        a_bi    = 8'd9;
        e_bi    = 3'd2;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("busy_mid_run", {31'd0, busy_o}, 32'd1);
        wait_valid(tail);
        check("p2_7_y",   {8'd0, y_bo}, 32'd128);
        check("p2_7_lat", 6 + tail,     32'd49);
        run_req(8'd9, 3'd2, lat_seen, busy0);
        check("b2b_y",   {8'd0, y_bo}, 32'd81);
        check("b2b_lat", lat_seen,     32'd9);

        // Asynchronous reset in the middle of a multiply
        @(posedge clk_i);
        #1;
        a_bi    = 8'd7;
        e_bi    = 3'd5;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy_o},  32'd0);
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_y",     {8'd0, y_bo},     32'd0);
        check("arst_ovf",   {31'd0, ovf_o},   32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) pulses++;
        end
        check("arst_no_valid", pulses, 32'd0);
        run_req(8'd4, 3'd2, lat_seen, busy0);
        check("post_rst_y",   {8'd0, y_bo}, 32'd16);
        check("post_rst_lat", lat_seen,     32'd9);

        // Randomised sweep against the reference model
        for (int i = 0; i < 24; i++) begin
            ra   = 8'($urandom_range(0, 255));
            re   = 3'($urandom_range(0, 7));
            rexp = ref_pow(ra, re);
            run_req(ra, re, lat_seen, busy0);
            check("rand_y",   {8'd0, y_bo},   {8'd0, rexp[23:0]});
            check("rand_ovf", {31'd0, ovf_o}, {31'd0, rexp[24]});
            check("rand_lat", lat_seen,       lat(int'(re), 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
